// File: rtl/stage1_fetch.sv
// Stage 1 instruction-fetch front end: owns the PC, drives the I-cache read port,
// applies Stage 2 redirects with a one-bubble kill, and keeps fetch performance counters.
module stage1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic [31:0]      alu_out,
  output logic [31:0]      icache_addr,
  output logic             icache_re,
  input  logic [31:0]      icache_dout,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  output logic             inst_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic             misalign_reg, misalign_next;
  logic [CNT_W-1:0] fetch_cnt_reg, bubble_cnt_reg, cycle_cnt_reg;
  logic             jump_eff;
  logic [31:0]      target;

  // Redirects are ignored while reset is held so the cache port shows RESET_PC.
  assign jump_eff = jump & reset;
  assign target   = {alu_out[31:2], 2'b00};

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    misalign_next = misalign_reg;
    inst_valid    = 1'b0;

    case (state_reg)
      BOOT: begin
        state_next = RUN;
        pc_next    = pc_reg;
      end
      RUN: begin
        state_next = RUN;
        pc_next    = pc_reg + 32'd4;
        inst_valid = ~jump_eff;
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_PC;
      end
    endcase

    if (jump_eff) begin
      pc_next       = target;
      misalign_next = misalign_reg | alu_out[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      misalign_reg   <= 1'b0;
      fetch_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
      cycle_cnt_reg  <= '0;
    end else if (!stall) begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      misalign_reg  <= misalign_next;
      cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      if (inst_valid)
        fetch_cnt_reg  <= fetch_cnt_reg + CNT_W'(1);
      else
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign icache_addr = pc_next;
  assign icache_re   = 1'b1;
  assign pc          = pc_reg;
  assign inst        = inst_valid ? icache_dout : NOP_INST;
  assign misalign    = misalign_reg;
  assign fetch_cnt   = fetch_cnt_reg;
  assign bubble_cnt  = bubble_cnt_reg;
  assign cycle_cnt   = cycle_cnt_reg;

endmodule

// File: tb/tb_stage1_fetch.sv
// Directed bench for stage1_fetch: reset, sequential fetch, redirects, misalign,
// stall with pending jump, PC wrap, boot-cycle jump and asynchronous reset mid-stall.
module tb_stage1_fetch;

  localparam logic [31:0] KEY = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, jump;
  logic [31:0] alu_out, icache_addr, icache_dout, pc, inst;
  logic        icache_re, inst_valid, misalign;
  logic [31:0] fetch_cnt, bubble_cnt, cycle_cnt;

  int checks = 0;
  int errors = 0;

  stage1_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .alu_out(alu_out),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .misalign(misalign),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous cache model: data for the address presented before the last live edge.
  initial icache_dout = 32'h0;
  always @(posedge clk)
    if (reset && !stall) icache_dout <= icache_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},     pc, 32'h2000);
    chk({tag, "_addr"},   icache_addr, 32'h2000);
    chk({tag, "_re"},     {31'b0, icache_re}, 32'd1);
    chk({tag, "_inst"},   inst, NOP);
    chk({tag, "_valid"},  {31'b0, inst_valid}, 32'd0);
    chk({tag, "_mis"},    {31'b0, misalign}, 32'd0);
    chk({tag, "_fetch"},  fetch_cnt, 32'd0);
    chk({tag, "_bubble"}, bubble_cnt, 32'd0);
    chk({tag, "_cycle"},  cycle_cnt, 32'd0);
  endtask

  task automatic chk_cnt(input string tag, input int f, input int b, input int c);
    chk({tag, "_fetch"},  fetch_cnt, 32'(f));
    chk({tag, "_bubble"}, bubble_cnt, 32'(b));
    chk({tag, "_cycle"},  cycle_cnt, 32'(c));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; jump = 1'b0; alu_out = 32'h0;

    // T1: reset held three cycles, then released
    repeat (3) @(negedge clk);
    #1 chk_reset_state("t1_rst");
    @(negedge clk); reset = 1'b1;
    #1;
    chk("t1_c0_inst",  inst, NOP);
    chk("t1_c0_valid", {31'b0, inst_valid}, 32'd0);
    chk("t1_c0_addr",  icache_addr, 32'h2000);
    $display("reset released: pc=%h addr=%h", pc, icache_addr);

    // T2: five sequential fetches from 0x2000
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t2_pc",    pc, 32'h2000 + 32'(4 * i));
      chk("t2_valid", {31'b0, inst_valid}, 32'd1);
      chk("t2_inst",  inst, (32'h2000 + 32'(4 * i)) ^ KEY);
      chk("t2_addr",  icache_addr, 32'h2004 + 32'(4 * i));
      $display("seq fetch: pc=%h inst=%h", pc, inst);
    end
    @(negedge clk); #1;
    chk("t2_pc_end", pc, 32'h2014);
    chk_cnt("t2", 5, 1, 6);

    // T3: taken jump to 0x3001 (bit0 dropped, no misalign)
    jump = 1'b1; alu_out = 32'h3001;
    #1;
    chk("t3_kill_inst",  inst, NOP);
    chk("t3_kill_valid", {31'b0, inst_valid}, 32'd0);
    chk("t3_addr",       icache_addr, 32'h3000);
    @(negedge clk); jump = 1'b0; alu_out = 32'h0;
    #1;
    chk("t3_pc",    pc, 32'h3000);
    chk("t3_inst",  inst, 32'h3000 ^ KEY);
    chk("t3_mis",   {31'b0, misalign}, 32'd0);
    chk_cnt("t3", 5, 2, 7);
    $display("jump 0x3001: pc=%h misalign=%0d", pc, misalign);

    // T4: jump target with bit1 set sets the sticky misalign flag
    @(negedge clk); #1;
    chk("t4_pc_pre", pc, 32'h3004);
    jump = 1'b1; alu_out = 32'h3002;
    #1 chk("t4_addr", icache_addr, 32'h3000);
    @(negedge clk); jump = 1'b0; alu_out = 32'h0;
    #1;
    chk("t4_pc",  pc, 32'h3000);
    chk("t4_mis", {31'b0, misalign}, 32'd1);
    chk_cnt("t4", 6, 3, 9);
    @(negedge clk); #1;
    chk("t4_mis_sticky", {31'b0, misalign}, 32'd1);
    chk("t4_pc_next",    pc, 32'h3004);
    $display("misalign jump: pc=%h misalign=%0d", pc, misalign);

    // T5: stall four edges with a pending jump to 0x4000
    stall = 1'b1; jump = 1'b1; alu_out = 32'h4000;
    #1 chk("t5_addr0", icache_addr, 32'h4000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_pc_hold",  pc, 32'h3004);
      chk("t5_addr",     icache_addr, 32'h4000);
      chk("t5_valid",    {31'b0, inst_valid}, 32'd0);
      chk_cnt("t5_hold", 7, 3, 10);
    end
    @(negedge clk); stall = 1'b0;
    #1 chk("t5_pc_last", pc, 32'h3004);
    chk_cnt("t5_last", 7, 3, 10);
    @(negedge clk); jump = 1'b0; alu_out = 32'h0;
    #1;
    chk("t5_pc",   pc, 32'h4000);
    chk("t5_inst", inst, 32'h4000 ^ KEY);
    chk_cnt("t5_rel", 7, 4, 11);
    $display("stall released: pc=%h cycle_cnt=%0d", pc, cycle_cnt);

    // T6: drive PC to the top of the address space and step across the wrap
    jump = 1'b1; alu_out = 32'hFFFF_FFFC;
    #1 chk("t6_addr_top", icache_addr, 32'hFFFF_FFFC);
    @(negedge clk); jump = 1'b0; alu_out = 32'h0;
    #1;
    chk("t6_pc_top", pc, 32'hFFFF_FFFC);
    chk("t6_addr_wrap", icache_addr, 32'h0);
    @(negedge clk); #1;
    chk("t6_pc_wrap", pc, 32'h0);
    chk("t6_inst_wrap", inst, 32'h0 ^ KEY);
    $display("wrap: pc=%h inst=%h", pc, inst);

    // Asynchronous reset mid-stall with a jump pending
    stall = 1'b1; jump = 1'b1; alu_out = 32'h5000;
    #1 reset = 1'b0;
    #1 chk_reset_state("t6_rst");
    $display("async reset mid-stall: pc=%h addr=%h", pc, icache_addr);

    // Jump during the boot cycle: redirect, still a bubble
    @(negedge clk); reset = 1'b1; stall = 1'b0; jump = 1'b1; alu_out = 32'h6000;
    #1;
    chk("t7_boot_addr",  icache_addr, 32'h6000);
    chk("t7_boot_valid", {31'b0, inst_valid}, 32'd0);
    chk("t7_boot_inst",  inst, NOP);
    @(negedge clk); jump = 1'b0; alu_out = 32'h0;
    #1;
    chk("t7_pc",    pc, 32'h6000);
    chk("t7_valid", {31'b0, inst_valid}, 32'd1);
    chk("t7_inst",  inst, 32'h6000 ^ KEY);
    chk_cnt("t7", 0, 1, 1);
    $display("boot jump: pc=%h inst=%h", pc, inst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
